cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single cache CPU-side port (address_bus, data_bus, rd, wr, ready) between two requesters, e.g. the SAYAC fetch unit (port 0) and a data/DMA master (port 1).
- Uses round-robin arbitration with one outstanding transaction at a time.
- Adds a watchdog so that a hung cache returns an error instead of stalling the system.

Parameters:
- DATA_WIDTH, 16, data width of requester and cache ports.
- ADR_WIDTH, 16, address width.
- TIMEOUT_CYCLES, 256, cycles in a grant state without mem_ready before the watchdog aborts; must be at least 2.
- CNT_WIDTH, 9, timeout counter width; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.
- ERR_DATA, 16'hDEAD, read data returned on timeout.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- r0_rd  in  1  port 0 read request, held until r0_ready.
- r0_wr  in  1  port 0 write request, held until r0_ready.
- r0_addr  in  ADR_WIDTH  port 0 address.
- r0_wdata  in  DATA_WIDTH  port 0 write data.
- r0_rdata  out  DATA_WIDTH  port 0 read data, valid while r0_ready=1.
- r0_ready  out  1  port 0 completion, one-cycle pulse.
- r1_rd, r1_wr, r1_addr, r1_wdata, r1_rdata, r1_ready: same as port 0, for port 1.
- mem_addr  out  ADR_WIDTH  cache address_bus.
- mem_data  inout  DATA_WIDTH  cache data_bus; driven only while mem_wr=1, else high-Z.
- mem_rd  out  1  cache rd.
- mem_wr  out  1  cache wr.
- mem_ready  in  1  cache ready; level, sampled on clk.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (async) forces:
  - state IDLE; all of mem_rd, mem_wr, mem_addr, r*_ready, r*_rdata, grant, timeout_err = 0.
  - mem_data high-Z; rr pointer = port 0 preferred; timeout counter = 0.
- Reset mid-transaction aborts immediately; no ready is ever returned for the aborted request.
- A request exists on port x when rx_rd | rx_wr. If both are high, the write wins and rd is ignored.
- FSM states: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE, on sampling requests at edge N:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both: grant the port named by the rr pointer.
  - At edge N the arbiter registers mem_addr, the write data and mem_rd/mem_wr from the winner, sets grant, and clears the counter. Outputs are valid in cycle N+1, so request-to-cache latency is 1 cycle.
- GRANTx:
  - Outputs are held constant. Requester inputs are ignored; withdrawing or changing a request does not abort the transaction.
  - The counter increments each cycle.
  - On the edge where mem_ready=1:
    - on a read, rx_rdata <= mem_data;
    - rx_ready <= 1, mem_rd/mem_wr <= 0;
    - the rr pointer moves to the other port;
    - next state is RELEASE.
  - On the edge where the counter reaches TIMEOUT_CYCLES-1 and mem_ready=0:
    - on a read, rx_rdata <= ERR_DATA;
    - rx_ready <= 1, timeout_err <= 1, mem_rd/mem_wr <= 0;
    - the pointer moves; next state is RELEASE.
  - If mem_ready and the timeout coincide, mem_ready wins and there is no error.
- RELEASE:
  - Exactly one cycle: rx_ready=1, grant still shown, cache signals idle.
  - Next edge: rx_ready <= 0, timeout_err <= 0, grant <= 00, state IDLE.
  - The guaranteed idle gap lets the cache see rd/wr fall.
- rx_rdata holds its value until the next read completion on that port.
- Back-to-back requests are granted at best 3 cycles apart (GRANT ≥1, RELEASE 1, IDLE 1).
- A requester that keeps its request high after ready is treated as a new request in IDLE.

Decomposition:
- Shared package cache_arb_pkg holds the state encoding (IDLE/GRANT0/GRANT1/RELEASE), the ERR_DATA default and the port index constants.
- One sub-module, rr_pick2:
  - combinational pick from req[1:0] and the pointer;
  - grant one-hot out;
  - reused by later N-port arbiters.

Test Plan:
- Single write: r0_wr, addr 0x0001, data 111; cache ready after 3 cycles -> mem_wr=1 with mem_addr=0x0001 and mem_data=111 one cycle after request; r0_ready pulses 1 cycle; grant 01 then 00.
- Contention: r0_rd@1024 and r1_rd@2048 raised in the same cycle after reset -> port 0 served first, then port 1; r1 rdata equals the cache value (e.g. 777); grants alternate 01, 10.
- Fairness: both ports request continuously for 6 transactions -> grant order 0,1,0,1,0,1; no port waits more than one other transaction.
- Timeout: TIMEOUT_CYCLES=8, r1_rd@9216, mem_ready held 0 -> timeout_err and r1_ready pulse 8 cycles after grant, r1_rdata=0xDEAD, mem_rd drops; a subsequent r0 write completes normally.
- Reset mid-grant: assert rst while GRANT0 waits on the cache -> mem_rd/mem_wr/grant go 0 and mem_data goes high-Z without a clock edge; r0_ready never pulses; after release, a new r1 request is granted first.
- Simultaneous rd/wr on port 0 plus mem_ready coinciding with the timeout edge -> a write is issued, and completion is a normal ready with timeout_err=0.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter family: FSM encoding,
// port indices and small helpers used by the arbiter and its tests.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT0  = 2'd1,
        ST_GRANT1  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam logic [1:0] GRANT_NONE = 2'b00;

    function automatic logic has_req(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two requester ports plus the cache control/status lines.
// The bidirectional cache data bus stays a plain inout on the arbiter.
interface cache_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADR_WIDTH  = 16
);
    logic                  r0_rd;
    logic                  r0_wr;
    logic [ADR_WIDTH-1:0]  r0_addr;
    logic [DATA_WIDTH-1:0] r0_wdata;
    logic [DATA_WIDTH-1:0] r0_rdata;
    logic                  r0_ready;

    logic                  r1_rd;
    logic                  r1_wr;
    logic [ADR_WIDTH-1:0]  r1_addr;
    logic [DATA_WIDTH-1:0] r1_wdata;
    logic [DATA_WIDTH-1:0] r1_rdata;
    logic                  r1_ready;

    logic [ADR_WIDTH-1:0]  mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic                  mem_ready;
    logic [1:0]            grant;
    logic                  timeout_err;

    modport slave (
        input  r0_rd, r0_wr, r0_addr, r0_wdata,
        input  r1_rd, r1_wr, r1_addr, r1_wdata,
        input  mem_ready,
        output r0_rdata, r0_ready, r1_rdata, r1_ready,
        output mem_addr, mem_rd, mem_wr, grant, timeout_err
    );

    modport master (
        output r0_rd, r0_wr, r0_addr, r0_wdata,
        output r1_rd, r1_wr, r1_addr, r1_wdata,
        output mem_ready,
        input  r0_rdata, r0_ready, r1_rdata, r1_ready,
        input  mem_addr, mem_rd, mem_wr, grant, timeout_err
    );

endinterface

// File: rtl/cache_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request always wins, a tie goes to the
// port named by the pointer. Purely combinational so wider arbiters can reuse it.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // One-hot winner selection
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache CPU-side port between two requesters, one transaction at a
// time, round-robin on contention, with a watchdog that aborts a hung cache.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 16,
    parameter int unsigned           ADR_WIDTH      = 16,
    parameter int unsigned           TIMEOUT_CYCLES = 256,
    parameter int unsigned           CNT_WIDTH      = 9,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_port_arbiter_if.slave   bus,
    inout  wire [DATA_WIDTH-1:0]  mem_data
);

    arb_state_e            state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [1:0]            grant_q, grant_d;
    logic                  rdy0_q, rdy0_d;
    logic                  rdy1_q, rdy1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  terr_q, terr_d;

    logic [1:0]            req_s;
    logic [1:0]            pick_s;
    logic                  timeout_s;
    logic                  cur_port_s;
    logic [DATA_WIDTH-1:0] rd_val_s;

    assign req_s      = {has_req(bus.r1_rd, bus.r1_wr), has_req(bus.r0_rd, bus.r0_wr)};
    assign timeout_s  = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign cur_port_s = (state_q == ST_GRANT1) ? PORT1 : PORT0;

    rr_pick2 u_pick (
        .req_i (req_s),
        .ptr_i (ptr_q),
        .gnt_o (pick_s)
    );

    // Next-state and next-output logic; every register holds unless told otherwise
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        grant_d    = grant_q;
        rdy0_d     = rdy0_q;
        rdy1_d     = rdy1_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        terr_d     = terr_q;
        rd_val_s   = ERR_DATA;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Write wins over read when a requester raises both
                if (pick_s[0]) begin
                    state_d    = ST_GRANT0;
                    grant_d    = 2'b01;
                    mem_addr_d = bus.r0_addr;
                    wdata_d    = bus.r0_wdata;
                    mem_wr_d   = bus.r0_wr;
                    mem_rd_d   = bus.r0_rd & ~bus.r0_wr;
                end else if (pick_s[1]) begin
                    state_d    = ST_GRANT1;
                    grant_d    = 2'b10;
                    mem_addr_d = bus.r1_addr;
                    wdata_d    = bus.r1_wdata;
                    mem_wr_d   = bus.r1_wr;
                    mem_rd_d   = bus.r1_rd & ~bus.r1_wr;
                end else begin
                    grant_d = GRANT_NONE;
                end
            end

            ST_GRANT0, ST_GRANT1: begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                // A ready on the watchdog edge still counts as a clean completion
                if (bus.mem_ready || timeout_s) begin
                    state_d  = ST_RELEASE;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    terr_d   = ~bus.mem_ready;
                    ptr_d    = ~cur_port_s;
                    rd_val_s = bus.mem_ready ? mem_data : ERR_DATA;
                    if (cur_port_s == PORT1) begin
                        rdy1_d = 1'b1;
                        if (mem_rd_q) begin
                            rdata1_d = rd_val_s;
                        end else begin
                            rdata1_d = rdata1_q;
                        end
                    end else begin
                        rdy0_d = 1'b1;
                        if (mem_rd_q) begin
                            rdata0_d = rd_val_s;
                        end else begin
                            rdata0_d = rdata0_q;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
                rdy0_d  = 1'b0;
                rdy1_d  = 1'b0;
                terr_d  = 1'b0;
                grant_d = GRANT_NONE;
            end

            default: begin
                state_d  = ST_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                grant_d  = GRANT_NONE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PORT0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            grant_q    <= GRANT_NONE;
            rdy0_q     <= 1'b0;
            rdy1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            grant_q    <= grant_d;
            rdy0_q     <= rdy0_d;
            rdy1_q     <= rdy1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            terr_q     <= terr_d;
        end
    end

    assign mem_data        = mem_wr_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
    assign bus.grant       = grant_q;
    assign bus.timeout_err = terr_q;
    assign bus.r0_ready    = rdy0_q;
    assign bus.r1_ready    = rdy1_q;
    assign bus.r0_rdata    = rdata0_q;
    assign bus.r1_rdata    = rdata1_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter: directed requests push expected
// cache accesses and completions; a negedge monitor pops and compares them.
module tb_cache_port_arbiter;
    import cache_arb_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wire [DW-1:0] mem_data;

    cache_port_arbiter_if #(.DATA_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

    cache_port_arbiter #(
        .DATA_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH(9), .ERR_DATA(16'hDEAD)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        terr;
        int          delta;
    } txn_t;

    txn_t exp_acc[$];
    txn_t exp_rsp[$];
    txn_t mt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    logic acc_prev = 1'b0;
    logic rdy_prev = 1'b0;
    logic [15:0] hold0 = 16'h0000;
    logic [15:0] hold1 = 16'h0000;
    logic [15:0] act_rdata;
    logic [15:0] exp_rdata;

    // cache model: cache_lat=0 means never answer
    int          cache_lat = 0;
    logic [15:0] cache_val = 16'h0000;
    logic        cache_drv = 1'b0;
    int          cyc_in = 0;

    assign mem_data = cache_drv ? cache_val : {16{1'bz}};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cache responder: raise mem_ready for one cycle after cache_lat cycles of access
    always @(negedge clk) begin
        if (rst || !(bus.mem_rd || bus.mem_wr)) begin
            cyc_in        = 0;
            bus.mem_ready = 1'b0;
            cache_drv     = 1'b0;
        end else begin
            cyc_in++;
            bus.mem_ready = (cache_lat > 0) && (cyc_in == cache_lat);
            cache_drv     = bus.mem_ready && bus.mem_rd;
        end
    end

    // Monitor: match cache access starts and completions against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            acc_prev = 1'b0;
            rdy_prev = 1'b0;
            hold0    = 16'h0000;
            hold1    = 16'h0000;
        end else begin
            if (rdy_prev) begin
                chk("ready_one_cycle", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
                chk("grant_after_release", {30'd0, bus.grant}, 32'd0);
                chk("terr_one_cycle", {31'd0, bus.timeout_err}, 32'd0);
            end
            if ((bus.mem_rd || bus.mem_wr) && !acc_prev) begin
                if (exp_acc.size() == 0) begin
                    fail_now("unexpected_cache_access");
                end else begin
                    mt = exp_acc.pop_front();
                    start_cyc = cyc;
                    chk("acc_addr", {16'd0, bus.mem_addr}, {16'd0, mt.addr});
                    chk("acc_rd", {31'd0, bus.mem_rd}, {31'd0, mt.rd});
                    chk("acc_wr", {31'd0, bus.mem_wr}, {31'd0, mt.wr});
                    chk("acc_grant", {30'd0, bus.grant}, mt.port ? 32'd2 : 32'd1);
                    if (mt.wr) chk("acc_wdata", {16'd0, mem_data}, {16'd0, mt.wdata});
                end
            end
            if (bus.r0_ready || bus.r1_ready) begin
                if (exp_rsp.size() == 0) begin
                    fail_now("unexpected_ready");
                end else begin
                    mt = exp_rsp.pop_front();
                    chk("rsp_port", {30'd0, bus.r1_ready, bus.r0_ready}, mt.port ? 32'd2 : 32'd1);
                    act_rdata = mt.port ? bus.r1_rdata : bus.r0_rdata;
                    exp_rdata = mt.rd ? mt.rdata : (mt.port ? hold1 : hold0);
                    chk("rsp_rdata", {16'd0, act_rdata}, {16'd0, exp_rdata});
                    if (mt.rd && mt.port) hold1 = mt.rdata;
                    if (mt.rd && !mt.port) hold0 = mt.rdata;
                    chk("rsp_timeout_err", {31'd0, bus.timeout_err}, {31'd0, mt.terr});
                    chk("rsp_latency", cyc - start_cyc, mt.delta);
                    chk("rsp_grant", {30'd0, bus.grant}, mt.port ? 32'd2 : 32'd1);
                    chk("rsp_cache_idle", {30'd0, bus.mem_rd, bus.mem_wr}, 32'd0);
                end
            end
            acc_prev = bus.mem_rd || bus.mem_wr;
            rdy_prev = bus.r0_ready || bus.r1_ready;
        end
    end

    function automatic txn_t mk(input logic p, input logic rd, input logic wr,
                                input logic [15:0] a, input logic [15:0] wd,
                                input logic [15:0] rdv, input logic te, input int dl);
        txn_t t;
        t.port = p; t.rd = rd; t.wr = wr; t.addr = a; t.wdata = wd;
        t.rdata = rdv; t.terr = te; t.delta = dl;
        return t;
    endfunction

    task automatic expect_txn(input txn_t t, input bit with_rsp);
        exp_acc.push_back(t);
        if (with_rsp) exp_rsp.push_back(t);
    endtask

    task automatic set_port(input logic p, input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            bus.r1_rd = rd; bus.r1_wr = wr; bus.r1_addr = a; bus.r1_wdata = d;
        end else begin
            bus.r0_rd = rd; bus.r0_wr = wr; bus.r0_addr = a; bus.r0_wdata = d;
        end
    endtask

    task automatic wait_ready(input logic p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(p ? bus.r1_ready : bus.r0_ready) && n < 200);
        if (n >= 200) fail_now(p ? "r1_ready_timeout" : "r0_ready_timeout");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
        chk("rst_grant", {30'd0, bus.grant}, 32'd0);
        chk("rst_ready", {30'd0, bus.r1_ready, bus.r0_ready}, 32'd0);
        chk("rst_rdata", {bus.r1_rdata, bus.r0_rdata}, 32'd0);
        chk("rst_timeout_err", {31'd0, bus.timeout_err}, 32'd0);

        // single write, cache answers after 3 cycles
        cache_lat = 3;
        expect_txn(mk(1'b0, 1'b0, 1'b1, 16'h0001, 16'd111, 16'h0000, 1'b0, 3), 1'b1);
        set_port(1'b0, 1'b0, 1'b1, 16'h0001, 16'd111);
        @(negedge clk);
        chk("write_latency_1", {31'd0, bus.mem_wr}, 32'd1);
        wait_ready(1'b0);
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // contention straight after reset: port 0 first
        do_reset();
        cache_lat = 2;
        cache_val = 16'd777;
        expect_txn(mk(1'b0, 1'b1, 1'b0, 16'd1024, 16'h0000, 16'd777, 1'b0, 2), 1'b1);
        expect_txn(mk(1'b1, 1'b1, 1'b0, 16'd2048, 16'h0000, 16'd777, 1'b0, 2), 1'b1);
        fork
            begin
                set_port(1'b0, 1'b1, 1'b0, 16'd1024, 16'h0000);
                wait_ready(1'b0);
                set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            begin
                set_port(1'b1, 1'b1, 1'b0, 16'd2048, 16'h0000);
                wait_ready(1'b1);
                set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        join

        // fairness: both ports request back to back, three each
        cache_lat = 1;
        cache_val = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            expect_txn(mk(1'b0, 1'b0, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i), 16'h0000, 1'b0, 1), 1'b1);
            expect_txn(mk(1'b1, 1'b1, 1'b0, 16'h0020 + 16'(i), 16'h0000, 16'h1234, 1'b0, 1), 1'b1);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    set_port(1'b0, 1'b0, 1'b1, 16'h0010 + 16'(i), 16'hA000 + 16'(i));
                    wait_ready(1'b0);
                end
                set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    set_port(1'b1, 1'b1, 1'b0, 16'h0020 + 16'(j), 16'h0000);
                    wait_ready(1'b1);
                end
                set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
            end
        join

        // watchdog: cache never answers a port 1 read
        cache_lat = 0;
        expect_txn(mk(1'b1, 1'b1, 1'b0, 16'd9216, 16'h0000, 16'hDEAD, 1'b1, TO), 1'b1);
        set_port(1'b1, 1'b1, 1'b0, 16'd9216, 16'h0000);
        wait_ready(1'b1);
        set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        cache_lat = 2;
        expect_txn(mk(1'b0, 1'b0, 1'b1, 16'h0042, 16'h55AA, 16'h0000, 1'b0, 2), 1'b1);
        set_port(1'b0, 1'b0, 1'b1, 16'h0042, 16'h55AA);
        wait_ready(1'b0);
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // reset while port 0 waits on the cache
        cache_lat = 0;
        expect_txn(mk(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0000, 1'b0, 0), 1'b0);
        set_port(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000);
        repeat (4) @(negedge clk);
        chk("pre_rst_grant", {30'd0, bus.grant}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
        chk("async_rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("async_rst_grant", {30'd0, bus.grant}, 32'd0);
        chk("async_rst_r0_ready", {31'd0, bus.r0_ready}, 32'd0);
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cache_lat = 2;
        cache_val = 16'h0BAD;
        expect_txn(mk(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h0BAD, 1'b0, 2), 1'b1);
        set_port(1'b1, 1'b1, 1'b0, 16'h0400, 16'h0000);
        wait_ready(1'b1);
        set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // rd+wr together, cache ready lands exactly on the watchdog edge
        cache_lat = TO;
        expect_txn(mk(1'b0, 1'b0, 1'b1, 16'h0500, 16'h0F0F, 16'h0000, 1'b0, TO), 1'b1);
        set_port(1'b0, 1'b1, 1'b1, 16'h0500, 16'h0F0F);
        wait_ready(1'b0);
        set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        repeat (4) @(negedge clk);
        chk("acc_queue_drained", exp_acc.size(), 32'd0);
        chk("rsp_queue_drained", exp_rsp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
